// File: rtl/ch552_uart_host_tx_pkg.sv
// ch552_uart_host_tx_pkg: shared UART constants and FSM state encoding
package ch552_uart_host_tx_pkg;
  localparam int UART_BIT_DIV_DEFAULT = 288;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
endpackage

// File: rtl/ch552_uart_fifo.sv
// ch552_uart_fifo: synchronous byte FIFO with head word presented from the storage flops
module ch552_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ch552_uart_host_tx.sv
// ch552_uart_host_tx: buffered 8N1 UART transmitter gated by the FPGA's clear-to-send
module ch552_uart_host_tx
  import ch552_uart_host_tx_pkg::*;
#(
  parameter int BIT_DIV = UART_BIT_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  input  logic                          fpga_cts,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CW = $clog2(BIT_DIV);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shreg, sh_n, head;
  logic [1:0] cts_q;
  logic cts_s, txd_n, pop, empty, full, tick, can_start;
  ch552_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(in_valid), .pop(pop), .din(in_data),
    .head(head), .full(full), .empty(empty), .level(fifo_level)
  );
  assign cts_s = cts_q[1];
  assign in_ready = ~full;
  assign busy = (state != IDLE) | ~empty;
  assign tick = cnt == CW'(BIT_DIV - 1);
  assign can_start = ~empty & cts_s;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_q <= '0;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      txd <= 1'b1;
    end else begin
      cts_q <= {cts_q[0], fpga_cts};
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      shreg <= sh_n;
      txd <= txd_n;
    end
  end
  // CTS is only consulted when a frame would begin; frames in flight always complete
  always_comb begin
    state_n = state;
    cnt_n = tick ? '0 : cnt + 1'b1;
    bit_n = bit_idx;
    sh_n = shreg;
    txd_n = txd;
    pop = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (can_start) begin
          pop = 1'b1;
          state_n = START;
          sh_n = head;
          txd_n = 1'b0;
        end
      end
      START: if (tick) begin
        state_n = DATA;
        bit_n = '0;
        txd_n = shreg[0];
      end
      DATA: if (tick) begin
        if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
          state_n = STOP;
          txd_n = 1'b1;
        end else begin
          bit_n = bit_idx + 1'b1;
          sh_n = shreg >> 1;
          txd_n = shreg[1];
        end
      end
      STOP: if (tick) begin
        if (can_start) begin
          pop = 1'b1;
          state_n = START;
          sh_n = head;
          txd_n = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
